aha_tlx_lane_responder: RTL and testbench
=========================================

# aha_tlx_lane_responder

Far-end TLX lane-training responder. It is the counterpart of the SoC's TLX training controller and sits in the partner device, such as the FPGA bridge, on the lane boundary of the TLX link. In functional mode it forwards the partner's five transmit lanes unchanged through one register stage. In training mode it replaces them with a repeating training pattern, checks the five receive lanes for the same pattern, and reports per-lane lock and error counts.

## Interface
- TRAIN_PATTERN, 32'hA5C3_9E17: pattern sent MSB-first on every TX lane and expected on every RX lane.
- LOCK_COUNT, 4: consecutive aligned pattern matches required for lane lock (range 1–15).
- TLX_REV_CLK  in  1: single clock for the block.
- TLX_REV_RESETn  in  1: asynchronous, active-low reset.
- TRAIN_EN  in  1: level; 1 = training mode, 0 = functional mode.
- RX_LANE_MASK  in  5: lanes that must lock before TRAIN_DONE can assert.
- TX_LANE_IN  in  5: functional TX bits. Bits [2:0] are REV payload bits 0, 24 and 64. Bits [4:3] are FWD payload TREADY and FWD flow TREADY.
- TX_LANE_OUT  out  5: registered TX lane drive.
- RX_LANE_IN  in  5: bits [2:0] are FWD payload bits 0, 16 and 39. Bits [4:3] are REV payload TREADY and REV flow TREADY.
- LANE_LOCK  out  5: per-lane lock.
- TRAIN_DONE  out  1: all masked lanes locked.
- ERR_CNT  out  40: 8 bits per lane; lane n occupies [8n+7:8n].

## Operation
- Top-level FSM has three states: IDLE, TRAIN and DONE.
  - IDLE → TRAIN when TRAIN_EN=1.
  - TRAIN → DONE when (LANE_LOCK & RX_LANE_MASK) == RX_LANE_MASK and RX_LANE_MASK != 0.
  - DONE → TRAIN when any masked lane drops lock.
  - Any state → IDLE when TRAIN_EN=0. This has priority over every other transition.
- TX path
  - In IDLE: TX_LANE_OUT <= TX_LANE_IN.
  - In TRAIN and DONE: every lane is driven with TRAIN_PATTERN[31-idx], where idx is a shared 5-bit counter.
  - idx is cleared on the IDLE→TRAIN transition and wraps from 31 to 0.
  - idx is not cleared on DONE↔TRAIN transitions.
- RX path, per lane; all of it runs only in TRAIN and DONE.
  - A 32-bit shift register takes the incoming bit each cycle: sr <= {sr[30:0], rx}.
  - A 5-bit phase counter and a 4-bit match counter track alignment.
  - Unarmed (match count 0):
    - If sr == TRAIN_PATTERN, set match count to 1 and phase to 0.
  - Armed (match count ≥ 1):
    - The match check happens only in the cycle where phase == 31.
    - Match: the match count increments, saturating at LOCK_COUNT.
    - Mismatch: match count and lock clear. If the lane was locked, its ERR_CNT increments, saturating at 255.
    - After a mismatch the lane is unarmed and re-searches starting the next cycle.
  - LANE_LOCK[n] = 1 when the match count equals LOCK_COUNT.
- On entry to TRAIN from IDLE: shift registers, match counters, lock and ERR_CNT all clear.
- On entry to IDLE: lock and match counters clear, and ERR_CNT holds its last value.
- TRAIN_DONE is 1 only in DONE.

## Timing
- Reset values:
  - TX_LANE_OUT = 0, LANE_LOCK = 0, TRAIN_DONE = 0, ERR_CNT = 0.
  - FSM = IDLE; idx, shift registers and counters = 0.
- In IDLE, TX_LANE_OUT lags TX_LANE_IN by exactly one cycle.
- When TRAIN_EN is sampled high at edge k:
  - state = TRAIN after edge k.
  - TX_LANE_OUT = TRAIN_PATTERN[31] after edge k+1.
- When TRAIN_EN is sampled low at edge k:
  - state = IDLE and LANE_LOCK = 0 after edge k.
  - TX_LANE_OUT carries functional data after edge k+1.
- LANE_LOCK, TRAIN_DONE and ERR_CNT are registered.
  - Lock asserts in the same edge that registers the LOCK_COUNT-th match.
  - TRAIN_DONE follows lock by one cycle.
- Minimum lock time from the first full pattern received: 32·(LOCK_COUNT−1) cycles.
- Asynchronous reset in mid-training returns the block to the reset values immediately. The block does not resume training until TRAIN_EN is sampled high again after reset is released.

## Configuration
- AHA_TLX_RESP_ERRCNT_EN
  - Defined: the per-lane 8-bit saturating error counters are built as described above.
  - Undefined: no counter flops are built and ERR_CNT is tied to 0. Lock and FSM behaviour are unchanged.

## Test plan
- Reset and pass-through: hold reset, then release with TRAIN_EN=0 and TX_LANE_IN=5'b10110 → TX_LANE_OUT=0 during reset and 5'b10110 one cycle after TX_LANE_IN is applied. LANE_LOCK=0 and TRAIN_DONE=0 throughout.
- Loopback lock: TX_LANE_OUT wired to RX_LANE_IN, RX_LANE_MASK=5'h1F, TRAIN_EN=1 → LANE_LOCK=5'h1F within 32·LOCK_COUNT+4 cycles, TRAIN_DONE=1 one cycle later, ERR_CNT=0.
- Phase skew: lane 2 loopback delayed by 7 cycles → lane 2 locks 7 cycles after lanes 0, 1, 3 and 4; TRAIN_DONE waits for lane 2.
- Error injection: after DONE, invert one bit on lane 1 within a single 32-bit period → LANE_LOCK[1] drops, state returns to TRAIN, ERR_CNT[15:8]=1, and lane 1 relocks. With the macro undefined, ERR_CNT stays 0.
- Mask and exit: RX_LANE_MASK=5'h07 with lanes 3 and 4 tied to 0 → TRAIN_DONE=1 once lanes 0–2 lock. Dropping TRAIN_EN → IDLE next cycle, LANE_LOCK=0, functional data on TX_LANE_OUT one cycle later.
- Error saturation and mid-run reset: 300 forced mismatches on locked lane 0 → ERR_CNT[7:0]=255. A reset pulse mid-training → all outputs return to 0 immediately.

Source files
------------

// File: rtl/aha_tlx_lane_responder.sv
// Far-end TLX lane-training responder: functional TX pass-through, or training-pattern TX with per-lane RX lock detection.
// Optional AHA_TLX_RESP_ERRCNT_EN builds the per-lane saturating error counters; otherwise ERR_CNT is tied to 0.
module aha_tlx_lane_responder #(
  parameter logic [31:0] TRAIN_PATTERN = 32'hA5C3_9E17,
  parameter int unsigned LOCK_COUNT    = 4
) (
  input  logic        TLX_REV_CLK,
  input  logic        TLX_REV_RESETn,
  input  logic        TRAIN_EN,
  input  logic [4:0]  RX_LANE_MASK,
  input  logic [4:0]  TX_LANE_IN,
  output logic [4:0]  TX_LANE_OUT,
  input  logic [4:0]  RX_LANE_IN,
  output logic [4:0]  LANE_LOCK,
  output logic        TRAIN_DONE,
  output logic [39:0] ERR_CNT
);

  localparam logic [3:0] LOCK_MAX = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {ST_IDLE, ST_TRAIN, ST_DONE} state_t;

  state_t      state, state_nxt;
  logic [4:0]  idx;
  logic [4:0]  tx_lane_p0;
  logic [31:0] sr    [5];
  logic [4:0]  phase [5];
  logic [3:0]  mcnt  [5];
  logic [4:0]  pat_hit;
  logic        active;
  logic        train_start;

  function automatic logic [3:0] sat_inc_match(input logic [3:0] v);
    return (v >= LOCK_MAX) ? LOCK_MAX : v + 4'd1;
  endfunction

  assign active      = (state != ST_IDLE);
  assign train_start = (state == ST_IDLE) && TRAIN_EN;
  assign TRAIN_DONE  = (state == ST_DONE);
  assign TX_LANE_OUT = tx_lane_p0;

  always_ff @(posedge TLX_REV_CLK or negedge TLX_REV_RESETn) begin
    if (!TLX_REV_RESETn) state <= ST_IDLE;
    else                 state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (!TRAIN_EN) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE:  state_nxt = ST_TRAIN;
        ST_TRAIN: if (((LANE_LOCK & RX_LANE_MASK) == RX_LANE_MASK) && (RX_LANE_MASK != 5'd0))
                    state_nxt = ST_DONE;
        ST_DONE:  if ((LANE_LOCK & RX_LANE_MASK) != RX_LANE_MASK)
                    state_nxt = ST_TRAIN;
        default:  state_nxt = ST_IDLE;
      endcase
    end
  end

  // TX stage: one register between lane inputs (or pattern) and the pads
  always_ff @(posedge TLX_REV_CLK or negedge TLX_REV_RESETn) begin
    if (!TLX_REV_RESETn) begin
      tx_lane_p0 <= '0;
      idx        <= '0;
    end else if (active) begin
      tx_lane_p0 <= {5{TRAIN_PATTERN[~idx]}};
      idx        <= idx + 5'd1;
    end else begin
      tx_lane_p0 <= TX_LANE_IN;
      idx        <= '0;
    end
  end

  always_comb begin
    pat_hit = '0;
    for (int n = 0; n < 5; n++) pat_hit[n] = (sr[n] == TRAIN_PATTERN);
  end

  // RX stage: per-lane shift register, alignment phase and match counting
  always_ff @(posedge TLX_REV_CLK or negedge TLX_REV_RESETn) begin
    if (!TLX_REV_RESETn) begin
      LANE_LOCK <= '0;
      for (int n = 0; n < 5; n++) begin
        sr[n]    <= '0;
        phase[n] <= '0;
        mcnt[n]  <= '0;
      end
    end else if (!TRAIN_EN) begin
      LANE_LOCK <= '0;
      for (int n = 0; n < 5; n++) mcnt[n] <= '0;
    end else if (train_start) begin
      LANE_LOCK <= '0;
      for (int n = 0; n < 5; n++) begin
        sr[n]    <= '0;
        phase[n] <= '0;
        mcnt[n]  <= '0;
      end
    end else if (active) begin
      for (int n = 0; n < 5; n++) begin
        sr[n] <= {sr[n][30:0], RX_LANE_IN[n]};
        if (mcnt[n] == 4'd0) begin
          if (pat_hit[n]) begin
            mcnt[n]      <= 4'd1;
            phase[n]     <= 5'd0;
            LANE_LOCK[n] <= (LOCK_MAX == 4'd1);
          end
        end else begin
          phase[n] <= phase[n] + 5'd1;
          if (phase[n] == 5'd31) begin
            if (pat_hit[n]) begin
              mcnt[n]      <= sat_inc_match(mcnt[n]);
              LANE_LOCK[n] <= (sat_inc_match(mcnt[n]) == LOCK_MAX);
            end else begin
              mcnt[n]      <= 4'd0;
              LANE_LOCK[n] <= 1'b0;
            end
          end
        end
      end
    end
  end

`ifdef AHA_TLX_RESP_ERRCNT_EN
  logic [7:0] err_cnt [5];
  logic [4:0] err_hit;

  function automatic logic [7:0] sat_inc_err(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A locked lane that misses its aligned pattern check is an error event
  always_comb begin
    err_hit = '0;
    for (int n = 0; n < 5; n++)
      err_hit[n] = active && TRAIN_EN && LANE_LOCK[n] && (mcnt[n] != 4'd0) &&
                   (phase[n] == 5'd31) && !pat_hit[n];
  end

  always_ff @(posedge TLX_REV_CLK or negedge TLX_REV_RESETn) begin
    if (!TLX_REV_RESETn) begin
      for (int n = 0; n < 5; n++) err_cnt[n] <= '0;
    end else if (train_start) begin
      for (int n = 0; n < 5; n++) err_cnt[n] <= '0;
    end else begin
      for (int n = 0; n < 5; n++)
        if (err_hit[n]) err_cnt[n] <= sat_inc_err(err_cnt[n]);
    end
  end

  always_comb begin
    ERR_CNT = '0;
    for (int n = 0; n < 5; n++) ERR_CNT[8*n +: 8] = err_cnt[n];
  end
`else
  assign ERR_CNT = '0;
`endif

endmodule

// File: tb/tb_aha_tlx_lane_responder.sv
// Directed bench for aha_tlx_lane_responder: pass-through table, loopback lock, skew, error injection, mask/exit, saturation, reset.
module tb_aha_tlx_lane_responder;

`ifdef AHA_TLX_RESP_ERRCNT_EN
  localparam logic [39:0] EXP_ERR1   = 40'd1;
  localparam logic [39:0] EXP_ERR255 = 40'd255;
`else
  localparam logic [39:0] EXP_ERR1   = 40'd0;
  localparam logic [39:0] EXP_ERR255 = 40'd0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        train_en = 1'b0;
  logic [4:0]  rx_mask = 5'h1F;
  logic [4:0]  tx_in = '0;
  logic [4:0]  tx_out;
  logic [4:0]  rx_in;
  logic [4:0]  lane_lock;
  logic        train_done;
  logic [39:0] err_cnt;

  logic [1:0]  rx_mode = 2'd0;
  logic [4:0]  inj = '0;
  logic [6:0]  dly = '0;

  int checks = 0;
  int failures = 0;
  int t_lock [5];
  int t_done;
  logic [4:0] tx1, tx2;

  typedef struct {
    logic [4:0] tx;
    logic [4:0] exp_out;
    logic [4:0] exp_lock;
    logic       exp_done;
  } vec_t;
  vec_t vecs [6];

  aha_tlx_lane_responder dut (
    .TLX_REV_CLK    (clk),
    .TLX_REV_RESETn (rst_n),
    .TRAIN_EN       (train_en),
    .RX_LANE_MASK   (rx_mask),
    .TX_LANE_IN     (tx_in),
    .TX_LANE_OUT    (tx_out),
    .RX_LANE_IN     (rx_in),
    .LANE_LOCK      (lane_lock),
    .TRAIN_DONE     (train_done),
    .ERR_CNT        (err_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) dly <= {dly[5:0], tx_out[2]};

  always_comb begin
    rx_in = '0;
    case (rx_mode)
      2'd1:    rx_in = tx_out ^ inj;
      2'd2:    rx_in = {tx_out[4:3], dly[6], tx_out[1:0]} ^ inj;
      2'd3:    rx_in = {2'b00, tx_out[2:0]};
      default: rx_in = '0;
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Raise TRAIN_EN from IDLE (edge 0) and record first lock/done cycle numbers.
  task automatic train_run(input int budget);
    train_en = 1'b1;
    step();
    for (int l = 0; l < 5; l++) t_lock[l] = -1;
    t_done = -1;
    for (int c = 1; c <= budget; c++) begin
      step();
      if (c == 1) tx1 = tx_out;
      if (c == 2) tx2 = tx_out;
      for (int l = 0; l < 5; l++)
        if (lane_lock[l] && t_lock[l] < 0) t_lock[l] = c;
      if (train_done && t_done < 0) t_done = c;
    end
  endtask

  task automatic go_idle();
    train_en = 1'b0;
    repeat (12) step();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t_drop;
    int timeouts;
    logic [4:0] snap;
    logic [4:0] prev;

    vecs[0] = '{5'b10110, 5'b10110, 5'b00000, 1'b0};
    vecs[1] = '{5'b01001, 5'b01001, 5'b00000, 1'b0};
    vecs[2] = '{5'b11111, 5'b11111, 5'b00000, 1'b0};
    vecs[3] = '{5'b00000, 5'b00000, 5'b00000, 1'b0};
    vecs[4] = '{5'b10101, 5'b10101, 5'b00000, 1'b0};
    vecs[5] = '{5'b01110, 5'b01110, 5'b00000, 1'b0};

    // Reset, then functional pass-through
    tx_in = 5'b10110;
    repeat (3) step();
    check("rst_tx", tx_out, 5'd0);
    check("rst_lock", lane_lock, 5'd0);
    check("rst_done", train_done, 1'b0);
    check("rst_err", err_cnt, 40'd0);
    rst_n = 1'b1;
    prev = 5'd0;
    for (int i = 0; i < 6; i++) begin
      tx_in = vecs[i].tx;
      check("pt_lag", tx_out, prev);
      step();
      check("pt_out", tx_out, vecs[i].exp_out);
      check("pt_lock", lane_lock, vecs[i].exp_lock);
      check("pt_done", train_done, vecs[i].exp_done);
      prev = vecs[i].exp_out;
    end
    tx_in = 5'd0;
    step();

    // Loopback lock on all lanes
    rx_mode = 2'd1;
    rx_mask = 5'h1F;
    train_run(140);
    check("lb_tx1", tx1, 5'h1F);
    check("lb_tx2", tx2, 5'h00);
    for (int l = 0; l < 5; l++) check_int("lb_lock_t", t_lock[l], 130);
    check_int("lb_done_t", t_done, 131);
    check("lb_lock", lane_lock, 5'h1F);
    check("lb_err", err_cnt, 40'd0);

    // Error injection on lane 1 while in DONE
    inj = 5'b00010;
    step();
    inj = 5'b00000;
    t_drop = -1;
    snap = '0;
    for (int c = 1; c <= 40; c++) begin
      step();
      if (!lane_lock[1]) begin
        t_drop = c;
        snap = lane_lock;
        break;
      end
    end
    check_int("inj_dropped", (t_drop > 0) ? 1 : 0, 1);
    check("inj_lock", snap, 5'h1D);
    step();
    check("inj_train", train_done, 1'b0);
    check("inj_err1", err_cnt[15:8], EXP_ERR1);
    check("inj_err_other", {err_cnt[39:16], err_cnt[7:0]}, 40'd0);
    t_done = -1;
    for (int c = 1; c <= 250; c++) begin
      step();
      if (train_done) begin
        t_done = c;
        break;
      end
    end
    check_int("inj_relock", (t_done > 0) ? 1 : 0, 1);
    check("inj_relock_lock", lane_lock, 5'h1F);

    // Error counter saturation on lane 0
    timeouts = 0;
    for (int k = 0; k < 300; k++) begin
      for (int c = 0; c < 250 && !lane_lock[0]; c++) step();
      if (!lane_lock[0]) timeouts++;
      inj = 5'b00001;
      step();
      inj = 5'b00000;
      for (int c = 0; c < 40 && lane_lock[0]; c++) step();
      if (lane_lock[0]) timeouts++;
    end
    check_int("sat_timeouts", timeouts, 0);
    check("sat_err0", err_cnt[7:0], EXP_ERR255);
    check("sat_err1", err_cnt[15:8], EXP_ERR1);

    // Phase skew: lane 2 delayed 7 cycles
    go_idle();
    rx_mode = 2'd2;
    train_run(150);
    check_int("sk_l0", t_lock[0], 130);
    check_int("sk_l1", t_lock[1], 130);
    check_int("sk_l2", t_lock[2], 137);
    check_int("sk_l3", t_lock[3], 130);
    check_int("sk_l4", t_lock[4], 130);
    check_int("sk_done", t_done, 138);
    check("sk_err_cleared", err_cnt, 40'd0);

    // Mask 07 with lanes 3,4 tied low, then exit training
    go_idle();
    rx_mode = 2'd3;
    rx_mask = 5'h07;
    train_run(140);
    check_int("mk_l0", t_lock[0], 130);
    check_int("mk_l2", t_lock[2], 130);
    check_int("mk_l3", t_lock[3], -1);
    check_int("mk_done", t_done, 131);
    check("mk_lock", lane_lock, 5'h07);
    train_en = 1'b0;
    tx_in = 5'b01101;
    step();
    check("ex_lock", lane_lock, 5'd0);
    check("ex_done", train_done, 1'b0);
    check_int("ex_tx_pattern", (tx_out == 5'h00 || tx_out == 5'h1F) ? 1 : 0, 1);
    step();
    check("ex_tx_func", tx_out, 5'b01101);

    // Mid-training asynchronous reset
    rx_mode = 2'd1;
    rx_mask = 5'h1F;
    tx_in = 5'd0;
    repeat (3) step();
    train_run(140);
    check("mr_pre_lock", lane_lock, 5'h1F);
    #2;
    rst_n = 1'b0;
    #1;
    check("mr_tx", tx_out, 5'd0);
    check("mr_lock", lane_lock, 5'd0);
    check("mr_done", train_done, 1'b0);
    check("mr_err", err_cnt, 40'd0);
    train_en = 1'b0;
    tx_in = 5'b00111;
    step();
    step();
    check("mr_hold_tx", tx_out, 5'd0);
    rst_n = 1'b1;
    step();
    check("mr_func_tx", tx_out, 5'b00111);
    check("mr_post_lock", lane_lock, 5'd0);
    check("mr_post_done", train_done, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
